// File: rtl/dm_resp_pkg.sv
// Shared definitions for the data-memory responder: widths, defaults,
// handshake state encoding and the captured request payload.
package dm_resp_pkg;

   localparam int unsigned ADDR_W          = 32;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned BE_W            = DATA_W / 8;
   localparam int unsigned WORD_IDX_W      = ADDR_W - 2;
   localparam int unsigned CNT_W           = 4;
   localparam int unsigned DEFAULT_DEPTH   = 3072;
   localparam int unsigned DEFAULT_LATENCY = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] pc;
   } txn_t;

   // Byte address to 32-bit word index.
   function automatic logic [WORD_IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:2];
   endfunction

endpackage

// File: rtl/dm_resp_if.sv
// Initiator <-> data-memory request/response bus with write-commit trace.
interface dm_resp_if;
   import dm_resp_pkg::*;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [BE_W-1:0]   be;
   logic [ADDR_W-1:0] pc;
   logic              ready;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic              rerr;
   logic              wtrace_valid;
   logic [ADDR_W-1:0] wtrace_pc;
   logic [ADDR_W-1:0] wtrace_addr;
   logic [DATA_W-1:0] wtrace_data;

   modport master (
      output req, we, addr, wdata, be, pc, rready,
      input  ready, rvalid, rdata, rerr,
             wtrace_valid, wtrace_pc, wtrace_addr, wtrace_data
   );

   modport slave (
      input  req, we, addr, wdata, be, pc, rready,
      output ready, rvalid, rdata, rerr,
             wtrace_valid, wtrace_pc, wtrace_addr, wtrace_data
   );

endinterface

// File: rtl/dm_resp_array.sv
// Word-addressed storage with byte-enable merge; whole array clears on reset.
module dm_array
   import dm_resp_pkg::*;
#(
   parameter  int unsigned DEPTH = DEFAULT_DEPTH,
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] rdata_c,
   output logic [DATA_W-1:0] merged_c
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_comb begin
      rdata_c = '0;
      if (32'(idx) < DEPTH) rdata_c = mem[idx];
   end

   // Word as it will look after the write: old bytes where be is clear.
   always_comb begin
      merged_c = rdata_c;
      for (int unsigned b = 0; b < BE_W; b++) begin
         if (be[b]) merged_c[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[idx] <= merged_c;
      end
   end

endmodule

// File: rtl/dm_resp.sv
// Single-outstanding data-memory responder: fixed-latency handshake FSM
// in front of dm_array, with a one-cycle write-commit trace.
module dm_resp
   import dm_resp_pkg::*;
#(
   parameter int unsigned DEPTH   = DEFAULT_DEPTH,
   parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
   input logic      clk,
   input logic      reset,
   dm_resp_if.slave bus
);

   localparam int unsigned        IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LATENCY - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   txn_t              cap_q, txn_c;
   logic              enter_resp_c, err_c, commit_c, hs_c;
   logic [IDX_W-1:0]  idx_c;
   logic [DATA_W-1:0] arr_rdata_c, arr_merged_c;

   assign bus.ready = (state_q == ST_IDLE);

   // With LATENCY==1 RESP is entered on the acceptance edge itself, so the
   // live bus fields stand in for the not-yet-captured ones while in IDLE.
   always_comb begin
      txn_c = cap_q;
      if (state_q == ST_IDLE) begin
         txn_c.we    = bus.we;
         txn_c.addr  = bus.addr;
         txn_c.wdata = bus.wdata;
         txn_c.be    = bus.be;
         txn_c.pc    = bus.pc;
      end
   end

   assign err_c    = (txn_c.addr[1:0] != 2'b00) || (32'(word_idx(txn_c.addr)) >= DEPTH);
   assign idx_c    = IDX_W'(word_idx(txn_c.addr));
   assign hs_c     = (state_q == ST_RESP) && bus.rready;
   assign commit_c = enter_resp_c && txn_c.we && !err_c && (txn_c.be != '0);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      enter_resp_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               cnt_d = CNT_LOAD;
               if (LATENCY == 1) begin
                  state_d      = ST_RESP;
                  enter_resp_c = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d      = ST_RESP;
               enter_resp_c = 1'b1;
            end
         end
         ST_RESP: begin
            if (bus.rready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if ((state_q == ST_IDLE) && bus.req) cap_q <= txn_c;
      end
   end

   // Response and trace registers; read data is sampled on the RESP-entry edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rvalid       <= 1'b0;
         bus.rdata        <= '0;
         bus.rerr         <= 1'b0;
         bus.wtrace_valid <= 1'b0;
         bus.wtrace_pc    <= '0;
         bus.wtrace_addr  <= '0;
         bus.wtrace_data  <= '0;
      end else begin
         bus.wtrace_valid <= commit_c;
         if (commit_c) begin
            bus.wtrace_pc   <= txn_c.pc;
            bus.wtrace_addr <= txn_c.addr;
            bus.wtrace_data <= arr_merged_c;
         end
         if (enter_resp_c) begin
            bus.rvalid <= 1'b1;
            bus.rerr   <= err_c;
            bus.rdata  <= (err_c || txn_c.we) ? '0 : arr_rdata_c;
         end else if (hs_c) begin
            bus.rvalid <= 1'b0;
            bus.rerr   <= 1'b0;
            bus.rdata  <= '0;
         end
      end
   end

   dm_array #(.DEPTH(DEPTH)) u_array (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (commit_c),
      .idx      (idx_c),
      .wdata    (txn_c.wdata),
      .be       (txn_c.be),
      .rdata_c  (arr_rdata_c),
      .merged_c (arr_merged_c)
   );

endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 3072, meaning number of 32-bit memory words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response valid (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req, input, 1, initiator request valid.
REQ-006 SHALL have port we, input, 1, 1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port addr, input, 32, byte address, base 0x0000_0000.
REQ-008 SHALL have port wdata, input, 32, write data.
REQ-009 SHALL have port be, input, 4, byte enables for writes; be[i] selects wdata[8i+7:8i].
REQ-010 SHALL have port pc, input, 32, initiator PC, captured for trace.
REQ-011 SHALL have port ready, output, 1, high when a request is accepted this cycle.
REQ-012 SHALL have port rvalid, output, 1, response valid.
REQ-013 SHALL have port rready, input, 1, initiator accepts the response.
REQ-014 SHALL have port rdata, output, 32, read data; 0 for writes and errors.
REQ-015 SHALL have port rerr, output, 1, response error flag.
REQ-016 SHALL have ports wtrace_valid (1), wtrace_pc (32), wtrace_addr (32), wtrace_data (32), all outputs, a one-cycle write-commit trace.

Function
REQ-017 SHALL implement states IDLE, WAIT, RESP.
REQ-018 SHALL assert ready only in IDLE (combinational, independent of req); req && ready at an edge is acceptance.
REQ-019 SHALL on acceptance capture we, addr, wdata, be, pc, and load the latency counter with LATENCY-1.
REQ-020 SHALL transition IDLE->RESP on acceptance when LATENCY==1, else IDLE->WAIT.
REQ-021 SHALL in WAIT decrement the counter each cycle and move to RESP on the edge where the counter is 1.
REQ-022 SHALL raise rvalid exactly LATENCY cycles after the acceptance edge and hold rvalid, rdata, rerr stable until rvalid && rready, then return to IDLE.
REQ-023 SHALL flag an error (rerr=1, no memory change, rdata=0) when addr[1:0]!=0 or addr[31:2] >= DEPTH.
REQ-024 SHALL sample read data at the edge entering RESP, so a read sees all writes committed earlier.
REQ-025 SHALL commit a non-error write at the edge entering RESP, updating only enabled bytes; be==0 is a legal no-op write with no error.
REQ-026 SHALL pulse wtrace_valid for the one cycle following a write commit, with wtrace_addr = captured addr, wtrace_data = full merged word after the write, wtrace_pc = captured pc; wtrace_valid SHALL be 0 for reads, errors and be==0.
REQ-027 SHALL ignore req outside IDLE; no queueing.
REQ-028 SHALL allow back-to-back transactions: if rready is high in the first RESP cycle, ready is high the next cycle.

Reset
REQ-029 SHALL, when reset is high at an edge, enter IDLE, clear every memory word to 0, clear counter and captured fields, and drive rvalid=0, rdata=0, rerr=0, wtrace_valid=0 and all other wtrace outputs 0; ready=1 the cycle after.
REQ-030 SHALL discard any in-flight transaction on reset with no write committed and no response issued.
REQ-031 SHALL give reset priority over acceptance, commit and response handshake in the same cycle.

Structure
REQ-032 SHALL place the state encoding (IDLE/WAIT/RESP), default DEPTH and LATENCY, and the address-to-word-index width in the shared CPU package.
REQ-033 SHALL split the word array with byte-enable write merging into one sub-module, dm_array; handshake FSM stays in dm_resp.

Verification
REQ-034 SHALL verify: reset, then read addr 0x0000_0010 -> rvalid after 2 cycles, rdata=0x0000_0000, rerr=0.
REQ-035 SHALL verify: write 0x1234_5678 to 0x0000_0008 be=4'b1111 pc=0x0000_3004 -> wtrace pc=0x0000_3004 addr=0x0000_0008 data=0x1234_5678; then write 0xAABB_CCDD be=4'b0011 -> wtrace data=0x1234_CCDD; read returns 0x1234_CCDD.
REQ-036 SHALL verify: read addr 0x0000_0006 -> rerr=1, rdata=0; write to 0x0000_3000 (word 3072) -> rerr=1, no wtrace, memory unchanged.
REQ-037 SHALL verify: rready held 0 for 5 cycles in RESP -> rvalid, rdata stable, ready=0, new req ignored; rready=1 -> next cycle ready=1.
REQ-038 SHALL verify: reset asserted in WAIT of a write to 0x0000_0004 -> no wtrace, later read of 0x0000_0004 returns 0.
REQ-039 SHALL verify: LATENCY=1 build, back-to-back read/write/read with rready tied 1 -> one response every 2 cycles, data correct.
